// File: rtl/vga_tile_scanout_if.sv
// Memory port B bundle between the tile scanout and the framebuffer RAM.
// The scanout is the master: it owns the address and write enable.
interface vga_mem_if;
  logic [9:0]  addr_b;
  logic        w_en_b;
  logic [15:0] data_b;

  modport master (
    output addr_b,
    output w_en_b,
    input  data_b
  );

  modport slave (
    input  addr_b,
    input  w_en_b,
    output data_b
  );
endinterface

// File: rtl/vga_tile_scanout.sv
// 640x480@60 VGA scanout of a 32x24 grid of solid RGB332 tiles.
// Reads one framebuffer word per pixel tick from memory port B.
module vga_tile_scanout #(
  parameter logic [9:0] FB_BASE = 10'd256,
  parameter int TILE   = 20,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_mem_if.master  mem,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int TW = $clog2(TILE);
  localparam int CW = $clog2(H_TOT / TILE + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_LAST =
    HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_LAST =
    VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [TW-1:0] SUB_LAST = TW'(TILE - 1);
  localparam logic [9:0] ROW_WORDS = 10'd32;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic          phase;
  logic          tick;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [TW-1:0] sub_x, sub_x_nxt;
  logic [TW-1:0] sub_y, sub_y_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [9:0]    row_base, row_base_nxt;
  logic [9:0]    addr_q, addr_nxt;
  logic          h_wrap, v_wrap, frame_wrap;
  logic          vis_nxt, vis_cur;
  logic          hs_cur, vs_cur;
  logic          unused_data;

  assign tick = phase;
  assign h_wrap = h_cnt == H_LAST;
  assign v_wrap = v_cnt == V_LAST;
  assign frame_wrap = (state_q == ST_RUN) && h_wrap && v_wrap;

  // First tick after reset presents (0,0) instead of advancing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    sub_x_nxt = '0;
    col_nxt = '0;
    sub_y_nxt = '0;
    row_base_nxt = '0;
    if (state_q == ST_RUN) begin
      h_nxt = h_cnt + 1'b1;
      sub_x_nxt = sub_x + 1'b1;
      col_nxt = col;
      v_nxt = v_cnt;
      sub_y_nxt = sub_y;
      row_base_nxt = row_base;
      if (sub_x == SUB_LAST) begin
        sub_x_nxt = '0;
        col_nxt = col + 1'b1;
      end
      if (h_wrap) begin
        h_nxt = '0;
        sub_x_nxt = '0;
        col_nxt = '0;
        v_nxt = v_cnt + 1'b1;
        sub_y_nxt = sub_y + 1'b1;
        if (sub_y == SUB_LAST) begin
          sub_y_nxt = '0;
          row_base_nxt = row_base + ROW_WORDS;
        end
        if (v_wrap) begin
          v_nxt = '0;
          sub_y_nxt = '0;
          row_base_nxt = '0;
        end
      end
    end
  end

  assign vis_nxt = (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);

  always_comb begin
    addr_nxt = FB_BASE;
    if (v_nxt < V_VIS_C)
      addr_nxt = FB_BASE + row_base_nxt;
    if (vis_nxt)
      addr_nxt = FB_BASE + row_base_nxt + 10'(col_nxt);
  end

  assign vis_cur = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_cur = !(h_cnt >= HS_FIRST && h_cnt <= HS_LAST);
  assign vs_cur = !(v_cnt >= VS_FIRST && v_cnt <= VS_LAST);
  assign unused_data = ^mem.data_b[15:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      phase <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      sub_x <= '0;
      col <= '0;
      sub_y <= '0;
      row_base <= '0;
      addr_q <= FB_BASE;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      phase <= ~phase;
      frame_start <= 1'b0;
      if (tick) begin
        state_q <= state_d;
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        sub_x <= sub_x_nxt;
        col <= col_nxt;
        sub_y <= sub_y_nxt;
        row_base <= row_base_nxt;
        addr_q <= addr_nxt;
        frame_start <= frame_wrap;
        // data_b now holds the word for the counters presented last tick
        if (state_q == ST_RUN) begin
          vga_r <= vis_cur ? mem.data_b[7:5] : '0;
          vga_g <= vis_cur ? mem.data_b[4:2] : '0;
          vga_b <= vis_cur ? mem.data_b[1:0] : '0;
          hsync <= hs_cur;
          vsync <= vs_cur;
          blank_n <= vis_cur;
        end
      end
    end
  end

  assign mem.addr_b = addr_q;
  assign mem.w_en_b = 1'b0;

endmodule

// File: tb/tb_vga_tile_scanout.sv
// Bench for vga_tile_scanout: full-timing and shrunk-timing instances
// compared every clock against a position-from-clock-count model.
module tb_vga_tile_scanout;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int tile;
  } tcfg_t;

  localparam tcfg_t CF = '{hv:640, hf:16, hs:96, hb:48,
    vv:480, vf:10, vs:2, vb:33, tile:20};
  localparam tcfg_t CS = '{hv:64, hf:4, hs:8, hb:4,
    vv:48, vf:2, vs:2, vb:3, tile:2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  vga_mem_if if_f ();
  vga_mem_if if_s ();

  logic [2:0] r_f, g_f, r_s, g_s;
  logic [1:0] b_f, b_s;
  logic hs_f, vs_f, bl_f, fs_f;
  logic hs_s, vs_s, bl_s, fs_s;

  vga_tile_scanout dut_f (
    .clk(clk), .reset(reset), .mem(if_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
    .hsync(hs_f), .vsync(vs_f), .blank_n(bl_f),
    .frame_start(fs_f)
  );

  vga_tile_scanout #(
    .TILE(2), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .reset(reset), .mem(if_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .hsync(hs_s), .vsync(vs_s), .blank_n(bl_s),
    .frame_start(fs_s)
  );

  logic [15:0] fb [1024];

  always @(posedge clk) begin
    if_f.data_b <= fb[if_f.addr_b];
    if_s.data_b <= fb[if_s.addr_b];
  end

  // clocks since the last clock edge that saw reset high
  int n = 0;
  always @(posedge clk) n <= reset ? 0 : n + 1;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0h want %0h",
               nm, n, act, exp);
      if (errors >= 200) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  function automatic int exp_addr(tcfg_t c, int h, int v);
    if (h < c.hv && v < c.vv)
      return 256 + (v / c.tile) * 32 + h / c.tile;
    if (v < c.vv)
      return 256 + (v / c.tile) * 32;
    return 256;
  endfunction

  // {addr_b, w_en_b, rgb, hsync, vsync, blank_n, frame_start}
  function automatic logic [22:0] exp_vec(tcfg_t c, int cnt);
    int ht, ft, k, p, h, v, a;
    logic [15:0] d;
    logic [7:0] rgb;
    logic vis, hsy, vsy, fs;
    ht = c.hv + c.hf + c.hs + c.hb;
    ft = ht * (c.vv + c.vf + c.vs + c.vb);
    k = cnt / 2;
    a = 256;
    rgb = '0;
    hsy = 1'b1;
    vsy = 1'b1;
    vis = 1'b0;
    if (k >= 1) begin
      p = (k - 1) % ft;
      a = exp_addr(c, p % ht, p / ht);
    end
    if (k >= 2) begin
      p = (k - 2) % ft;
      h = p % ht;
      v = p / ht;
      vis = h < c.hv && v < c.vv;
      d = fb[exp_addr(c, h, v)];
      rgb = vis ? d[7:0] : 8'h00;
      hsy = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
      vsy = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
    end
    fs = (cnt % 2 == 0) && k >= 2 && ((k - 1) % ft == 0);
    return {a[9:0], 1'b0, rgb, hsy, vsy, vis, fs};
  endfunction

  logic [22:0] obs_f, obs_s;
  assign obs_f = {if_f.addr_b, if_f.w_en_b, r_f, g_f, b_f,
                  hs_f, vs_f, bl_f, fs_f};
  assign obs_s = {if_s.addr_b, if_s.w_en_b, r_s, g_s, b_s,
                  hs_s, vs_s, bl_s, fs_s};

  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("full_out", obs_f, exp_vec(CF, n));
      check("small_out", obs_s, exp_vec(CS, n));
    end
  end

  // pulse period / width measurement, in clocks
  int per_x [4] = '{1600, 160, 8800, 8800};
  int wid_x [4] = '{192, 16, 320, 1};
  int last_on [4] = '{-1, -1, -1, -1};
  bit prev [4] = '{0, 0, 0, 0};
  int cyc = 0;
  logic [3:0] act;
  assign act = {fs_s, ~vs_s, ~hs_s, ~hs_f};

  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (reset || !armed) begin
        last_on[i] = -1;
      end else begin
        if (act[i] && !prev[i]) begin
          if (last_on[i] >= 0)
            check($sformatf("period%0d", i),
                  cyc - last_on[i], per_x[i]);
          last_on[i] = cyc;
        end
        if (!act[i] && prev[i] && last_on[i] >= 0)
          check($sformatf("width%0d", i),
                cyc - last_on[i], wid_x[i]);
      end
      prev[i] = act[i];
    end
  end

  task automatic fill(input int mode);
    for (int i = 0; i < 1024; i++) begin
      unique case (mode)
        1: fb[i] = 16'($urandom);
        2: fb[i] = 16'hFFFF;
        3: fb[i] = (i == 257) ? 16'h00E3 : 16'h0000;
        default: ;
      endcase
    end
  endtask

  // called at a falling edge; holds reset for len rising edges
  task automatic reset_fill(input int len, input int mode);
    #1 reset = 1'b1;
    fill(mode);
    repeat (len) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_n(input int t);
    do @(negedge clk); while (n < t);
  endtask

  initial begin
    fill(3);
    @(posedge clk);
    #1 armed = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_addr", if_f.addr_b, 256);
    check("rst_wen", if_f.w_en_b, 0);
    check("rst_sync", {hs_f, vs_f, bl_f, fs_f}, 4'b1100);
    check("rst_rgb", {r_f, g_f, b_f}, 0);
    #1 reset = 1'b0;

    wait_n(2);     check("a_0_0", if_f.addr_b, 256);
    wait_n(40);    check("a_19_0", if_f.addr_b, 256);
    wait_n(42);    check("a_20_0", if_f.addr_b, 257);
                   check("p_19_0", {r_f, g_f, b_f}, 0);
                   check("bl_19_0", bl_f, 1);
    wait_n(44);    check("r_20_0", r_f, 7);
                   check("g_20_0", g_f, 0);
                   check("b_20_0", b_f, 3);
                   check("bl_20_0", bl_f, 1);
    wait_n(82);    check("p_39_0", {r_f, g_f, b_f}, 8'hE3);
    wait_n(84);    check("p_40_0", {r_f, g_f, b_f}, 0);
    wait_n(1280);  check("a_639_0", if_f.addr_b, 287);
    wait_n(1314);  check("hs_655", hs_f, 1);
    wait_n(1316);  check("hs_656", hs_f, 0);
    wait_n(1402);  check("a_700_0", if_f.addr_b, 256);
    wait_n(1404);  check("bl_700_0", bl_f, 0);
    wait_n(30402); check("a_0_19", if_f.addr_b, 256);
    wait_n(30482); check("p_39_19", {r_f, g_f, b_f}, 8'hE3);
    wait_n(32002); check("a_0_20", if_f.addr_b, 288);
    wait_n(32044); check("p_20_20", {r_f, g_f, b_f}, 0);
    wait_n(32100);

    reset_fill(3, 1);
    wait_n(7648);  check("s_a_last", if_s.addr_b, 1023);
    wait_n(7650);  check("s_a_hblank", if_s.addr_b, 992);
    wait_n(7682);  check("s_a_vblank", if_s.addr_b, 256);
    wait_n(17800);

    reset_fill(2, 2);
    wait_n(4);     check("ff_0_0", {r_f, g_f, b_f}, 8'hFF);
                   check("ff_bl", bl_f, 1);
    wait_n(130);   check("ff_s_63", {r_s, g_s, b_s}, 8'hFF);
    wait_n(132);   check("ff_s_64", {r_s, g_s, b_s}, 0);
                   check("ff_s_bl64", bl_s, 0);
    wait_n(1284);  check("ff_640", {r_f, g_f, b_f}, 0);
    wait_n(9000);

    reset_fill(1, 1);
    wait_n(3262);  check("s_a_30_20", if_s.addr_b, 591);
    reset_fill(1, 0);
    wait_n(2);     check("mid_addr", if_s.addr_b, 256);
                   check("mid_fs", fs_s, 0);
    wait_n(2000);

    repeat (4) begin
      reset_fill(int'($urandom_range(1, 4)), 1);
      wait_n(int'($urandom_range(300, 2000)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_500_000;
    errors++;
    $display("FAIL watchdog n=%0d got timeout want finish", n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
